panda_bits: RTL and testbench
=============================

PANDA_BITS -- requirements
Module: panda_bits

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk_i  input  1  single system clock; all logic on rising edge.
REQ-003 reset_i  input  1  reset, synchronous, active-high; sampled on rising clk_i.
REQ-004 SOFTA_SET  input  1  software-written level for soft output A, held static between register writes.
REQ-005 SOFTB_SET  input  1  software-written level for soft output B.
REQ-006 SOFTC_SET  input  1  software-written level for soft output C.
REQ-007 SOFTD_SET  input  1  software-written level for soft output D.
REQ-008 zero_o  output  1  constant logic-0 system-bus bit.
REQ-009 one_o  output  1  constant logic-1 system-bus bit.
REQ-010 softa_o  output  1  registered copy of SOFTA_SET.
REQ-011 softb_o  output  1  registered copy of SOFTB_SET.
REQ-012 softc_o  output  1  registered copy of SOFTC_SET.
REQ-013 softd_o  output  1  registered copy of SOFTD_SET.

Function
REQ-014 Each softX_o SHALL be a flip-flop loaded from SOFTX_SET on every rising clk_i edge when reset_i is low.
REQ-015 Latency SET-to-output SHALL be exactly 1 clock: value present before edge N appears on softX_o after edge N.
REQ-016 The four channels SHALL be independent; simultaneous changes on any combination SHALL all appear on the same edge.
REQ-017 No edge detection, strobe, or handshake SHALL be applied; softX_o follows the level, including toggles every cycle.
REQ-018 A SET input held for any number of cycles SHALL keep softX_o constant at that value with no glitch.
REQ-019 zero_o SHALL be driven constant 0 at all times, including during and after reset.
REQ-020 one_o SHALL be driven constant 1 at all times, including during and after reset.
REQ-021 softX_o SHALL be glitch-free register outputs; no combinational path from SET inputs to outputs.

Reset
REQ-022 While reset_i is high at a rising edge, softa_o..softd_o SHALL load 0 regardless of SET inputs.
REQ-023 Reset SHALL have priority over SET inputs on the same edge.
REQ-024 On the first edge with reset_i low, softX_o SHALL load the current SETX value (1-cycle latency resumes immediately).
REQ-025 Power-up register value SHALL be 0 for all soft outputs.

Verification
REQ-026 Reset high 3 cycles with all SET=1 -> softa..d_o=0, zero_o=0, one_o=1; reset low -> all soft outputs 1 after one edge.
REQ-027 SOFTA_SET 0->1 at edge N, others 0 -> softa_o=1 from edge N+1, softb..d_o stay 0.
REQ-028 SOFTA..D_SET pattern 1010 then 0101 on consecutive cycles -> outputs show 1010 then 0101, each delayed one cycle.
REQ-029 SOFTC_SET toggled every cycle for 16 cycles -> softc_o toggles every cycle, one cycle behind, no missed toggles.
REQ-030 Reset asserted mid-stream with SET=1111 -> outputs 0000 on that edge; zero_o/one_o unchanged at 0/1 throughout.
REQ-031 Random SET stimulus 1000 cycles -> softX_o(N+1)==SETX(N) every cycle, compared on each rising edge.

Source files
------------

// File: rtl/panda_bits.sv
// Constant system-bus bits plus four independent software-level outputs,
// each registered once so the outputs are clean flop outputs.
module panda_bits (
    input  logic clk_i,
    input  logic reset_i,
    input  logic SOFTA_SET,
    input  logic SOFTB_SET,
    input  logic SOFTC_SET,
    input  logic SOFTD_SET,
    output logic zero_o,
    output logic one_o,
    output logic softa_o,
    output logic softb_o,
    output logic softc_o,
    output logic softd_o
);

    logic [3:0] set_in;
    logic [3:0] soft_d;
    // Declaration value gives the all-zero power-up state on the FPGA.
    logic [3:0] soft_q = 4'b0000;

    assign set_in = {SOFTA_SET, SOFTB_SET, SOFTC_SET, SOFTD_SET};

    always_comb begin
        soft_d = set_in;
        if (reset_i) begin
            soft_d = 4'b0000;
        end
    end

    always_ff @(posedge clk_i) begin
        soft_q <= soft_d;
    end

    assign zero_o  = 1'b0;
    assign one_o   = 1'b1;
    assign softa_o = soft_q[3];
    assign softb_o = soft_q[2];
    assign softc_o = soft_q[1];
    assign softd_o = soft_q[0];

endmodule

// File: tb/tb_panda_bits.sv
// Self-checking bench for panda_bits: directed cases then random levels and
// resets, all compared against a one-edge-delay reference model.
module tb_panda_bits;

    logic clk = 1'b0;
    logic reset_i = 1'b0;
    logic seta = 1'b0, setb = 1'b0, setc = 1'b0, setd = 1'b0;
    logic zero_o, one_o, softa_o, softb_o, softc_o, softd_o;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [3:0] exp_soft = 4'b0000;  // model: value the outputs must hold now

    panda_bits dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .SOFTA_SET (seta),
        .SOFTB_SET (setb),
        .SOFTC_SET (setc),
        .SOFTD_SET (setd),
        .zero_o    (zero_o),
        .one_o     (one_o),
        .softa_o   (softa_o),
        .softb_o   (softb_o),
        .softc_o   (softc_o),
        .softd_o   (softd_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] soft_vec();
        return {softa_o, softb_o, softc_o, softd_o};
    endfunction

    // One transaction: apply inputs away from the edge, confirm outputs did
    // not move combinationally, clock once, then compare against the model.
    task automatic step(input string tag, input logic rst, input logic [3:0] set);
        @(negedge clk);
        reset_i = rst;
        {seta, setb, setc, setd} = set;
        #1;
        check_val({tag, "_hold"}, {4'b0, soft_vec()}, {4'b0, exp_soft});
        @(posedge clk);
        exp_soft = rst ? 4'b0000 : set;
        #1;
        check_val(tag, {4'b0, soft_vec()}, {4'b0, exp_soft});
        check_val({tag, "_zero"}, {7'b0, zero_o}, 8'd0);
        check_val({tag, "_one"}, {7'b0, one_o}, 8'd1);
        $display("step %-10s rst=%b set=%b out=%b exp=%b", tag, rst, set, soft_vec(), exp_soft);
    endtask

    initial begin
        logic [3:0] r;
        logic       rr;
        #1;
        check_val("powerup", {4'b0, soft_vec()}, 8'd0);
        check_val("pu_zero", {7'b0, zero_o}, 8'd0);
        check_val("pu_one", {7'b0, one_o}, 8'd1);

        for (int i = 0; i < 3; i++) step("rst_all1", 1'b1, 4'b1111);
        step("rel_all1", 1'b0, 4'b1111);

        step("clr", 1'b0, 4'b0000);
        step("a_rise", 1'b0, 4'b1000);
        step("a_hold", 1'b0, 4'b1000);

        step("pat1010", 1'b0, 4'b1010);
        step("pat0101", 1'b0, 4'b0101);

        for (int i = 0; i < 16; i++) step("c_toggle", 1'b0, (i % 2 == 0) ? 4'b0010 : 4'b0000);

        step("pre_mid", 1'b0, 4'b1111);
        step("pre_mid", 1'b0, 4'b1111);
        step("rst_mid", 1'b1, 4'b1111);
        step("post_mid", 1'b0, 4'b1111);
        step("post_mid", 1'b0, 4'b0110);

        for (int i = 0; i < 1000; i++) begin
            r  = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 49) == 0);
            step("random", rr, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
